// File: rtl/mips_pkg.sv
// Shared definitions for the 5-stage MIPS-lite core: encodings, ALU and
// forwarding selects, pipeline register layouts and small helpers.
package mips_pkg;

    localparam int XLEN = 32;
    localparam int RW   = 5;

    localparam logic [XLEN-1:0] NOP = 32'h0000_0000;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2a;

    typedef enum logic [2:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_LUI
    } alu_op_e;

    typedef enum logic [1:0] {
        FWD_RF, FWD_EXMEM, FWD_MEMWB
    } fwd_sel_e;

    // All-zero values of these registers are bubbles: NOP, no writes.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
        logic            pred_taken;
    } ifid_t;

    typedef struct packed {
        logic            reg_we;
        logic [RW-1:0]   rd;
        alu_op_e         alu_op;
        logic            alu_imm;
        logic [XLEN-1:0] imm;
        logic            mem_rd;
        logic            mem_wr;
        logic [RW-1:0]   rs;
        logic [RW-1:0]   rt;
        logic [XLEN-1:0] rs_val;
        logic [XLEN-1:0] rt_val;
    } idex_t;

    typedef struct packed {
        logic            reg_we;
        logic [RW-1:0]   rd;
        logic            mem_rd;
        logic            mem_wr;
        logic [XLEN-1:0] alu;
        logic [XLEN-1:0] st_data;
    } exmem_t;

    typedef struct packed {
        logic            reg_we;
        logic [RW-1:0]   rd;
        logic [XLEN-1:0] wdata;
    } memwb_t;

    function automatic logic [XLEN-1:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

    // A stage produces register r if it writes it and r is not $0.
    function automatic logic hit(input logic we, input logic [RW-1:0] rd, input logic [RW-1:0] r);
        return we && (rd != '0) && (rd == r);
    endfunction

endpackage

// File: rtl/mips_hazard_unit.sv
// Hazard unit: stall/flush arbitration and forwarding selects for the
// EX operands and the ID branch comparator.
module mips_hazard_unit
    import mips_pkg::*;
(
    input  logic [RW-1:0] id_rs,
    input  logic [RW-1:0] id_rt,
    input  logic          id_beq,
    input  logic          redirect_req,
    input  logic [RW-1:0] ex_rs,
    input  logic [RW-1:0] ex_rt,
    input  logic [RW-1:0] ex_rd,
    input  logic          ex_we,
    input  logic          ex_mrd,
    input  logic [RW-1:0] mem_rd,
    input  logic          mem_we,
    input  logic          mem_mrd,
    input  logic [RW-1:0] wb_rd,
    input  logic          wb_we,
    output logic          stall,
    output logic          flush,
    output fwd_sel_e      fwd_a,
    output fwd_sel_e      fwd_b,
    output fwd_sel_e      br_fwd_a,
    output fwd_sel_e      br_fwd_b
);

    logic ld_use;
    logic br_stall;

    // Branch operand stalls beat redirects; redirects beat load-use stalls.
    always_comb begin
        ld_use   = ex_mrd && (hit(ex_we, ex_rd, id_rs) || hit(ex_we, ex_rd, id_rt));
        br_stall = id_beq && (hit(ex_we, ex_rd, id_rs) || hit(ex_we, ex_rd, id_rt) ||
                              hit(mem_we && mem_mrd, mem_rd, id_rs) ||
                              hit(mem_we && mem_mrd, mem_rd, id_rt));
        flush    = redirect_req && !br_stall;
        stall    = br_stall || (ld_use && !flush);
    end

    // EX operands: youngest producer first.
    always_comb begin
        fwd_a = FWD_RF;
        fwd_b = FWD_RF;
        if (hit(mem_we, mem_rd, ex_rs))     fwd_a = FWD_EXMEM;
        else if (hit(wb_we, wb_rd, ex_rs))  fwd_a = FWD_MEMWB;
        if (hit(mem_we, mem_rd, ex_rt))     fwd_b = FWD_EXMEM;
        else if (hit(wb_we, wb_rd, ex_rt))  fwd_b = FWD_MEMWB;
    end

    // Comparator operands: a load in MEM is stalled on, so EX/MEM only supplies ALU results.
    always_comb begin
        br_fwd_a = FWD_RF;
        br_fwd_b = FWD_RF;
        if (hit(mem_we && !mem_mrd, mem_rd, id_rs)) br_fwd_a = FWD_EXMEM;
        else if (hit(wb_we, wb_rd, id_rs))          br_fwd_a = FWD_MEMWB;
        if (hit(mem_we && !mem_mrd, mem_rd, id_rt)) br_fwd_b = FWD_EXMEM;
        else if (hit(wb_we, wb_rd, id_rt))          br_fwd_b = FWD_MEMWB;
    end

endmodule

// File: rtl/mips5_pipe_core.sv
// 5-stage MIPS-lite core running a program preloaded into im[].
// Optional macro BHT_PREDICT_EN: IF predicts beq with a 2-bit counter table;
// otherwise branches are statically predicted not-taken.
module mips5_pipe_core
    import mips_pkg::*;
#(
    parameter int              INST_MEM_LENGTH = 1024,
    parameter int              DATA_MEM_LENGTH = 1024,
    parameter logic [XLEN-1:0] RESET_PC        = 32'h0000_0000
) (
    input logic clk,
    input logic pc_rst_n
);

    logic [XLEN-1:0] im       [0:INST_MEM_LENGTH-1];
    logic [XLEN-1:0] reg_file [0:31];
    logic [XLEN-1:0] dm       [0:DATA_MEM_LENGTH-1];
    logic [1:0]      bht      [0:7];

    logic [XLEN-1:0] pc, if_inst, if_next;
    logic            if_pred;
    ifid_t           ifid;
    idex_t           idex, idex_n;
    exmem_t          exmem, exmem_n;
    memwb_t          memwb, memwb_n;

    logic [5:0]      id_op, id_fn;
    logic [RW-1:0]   id_rs, id_rt, id_rd;
    logic            id_beq, id_j;
    logic [XLEN-1:0] id_rs_val, id_rt_val, br_a, br_b, id_pcp4, br_target, j_target;
    logic            br_taken, redirect_req;
    logic [XLEN-1:0] redirect_pc;

    logic            stall, flush;
    fwd_sel_e        fwd_a, fwd_b, br_fwd_a, br_fwd_b;

    logic [XLEN-1:0] ex_a, ex_b_reg, ex_b, ex_alu, mem_ld;

    logic            wb_we;
    logic [RW-1:0]   wb_rd;
    logic [XLEN-1:0] wb_data;

    assign wb_we   = memwb.reg_we;
    assign wb_rd   = memwb.rd;
    assign wb_data = memwb.wdata;

    // IF: fetch and, when enabled, redirect predicted-taken beq at once.
    always_comb begin
        if_inst = im[pc[11:2]];
        if_next = pc + 32'd4;
        if_pred = 1'b0;
`ifdef BHT_PREDICT_EN
        if (if_inst[31:26] == OP_BEQ && bht[pc[4:2]][1]) begin
            if_pred = 1'b1;
            if_next = pc + 32'd4 + (sext16(if_inst[15:0]) << 2);
        end
`endif
    end

    // ID: decode, register read with WB write-through, branch/jump resolution.
    always_comb begin
        id_op   = ifid.inst[31:26];
        id_rs   = ifid.inst[25:21];
        id_rt   = ifid.inst[20:16];
        id_rd   = ifid.inst[15:11];
        id_fn   = ifid.inst[5:0];
        id_beq  = 1'b0;
        id_j    = 1'b0;
        idex_n  = '0;
        idex_n.rs = id_rs;
        idex_n.rt = id_rt;

        id_rs_val = (id_rs == '0) ? '0 : (hit(wb_we, wb_rd, id_rs) ? wb_data : reg_file[id_rs]);
        id_rt_val = (id_rt == '0) ? '0 : (hit(wb_we, wb_rd, id_rt) ? wb_data : reg_file[id_rt]);
        idex_n.rs_val = id_rs_val;
        idex_n.rt_val = id_rt_val;

        case (id_op)
            OP_RTYPE: begin
                idex_n.rd = id_rd;
                idex_n.reg_we = 1'b1;
                case (id_fn)
                    FN_ADDU: idex_n.alu_op = ALU_ADD;
                    FN_SUBU: idex_n.alu_op = ALU_SUB;
                    FN_AND:  idex_n.alu_op = ALU_AND;
                    FN_OR:   idex_n.alu_op = ALU_OR;
                    FN_SLT:  idex_n.alu_op = ALU_SLT;
                    default: idex_n.reg_we = 1'b0;
                endcase
            end
            OP_ORI: begin
                idex_n.reg_we = 1'b1; idex_n.rd = id_rt; idex_n.alu_op = ALU_OR;
                idex_n.alu_imm = 1'b1; idex_n.imm = {16'h0, ifid.inst[15:0]};
            end
            OP_LUI: begin
                idex_n.reg_we = 1'b1; idex_n.rd = id_rt; idex_n.alu_op = ALU_LUI;
                idex_n.alu_imm = 1'b1; idex_n.imm = {16'h0, ifid.inst[15:0]};
            end
            OP_LW: begin
                idex_n.reg_we = 1'b1; idex_n.rd = id_rt; idex_n.mem_rd = 1'b1;
                idex_n.alu_imm = 1'b1; idex_n.imm = sext16(ifid.inst[15:0]);
            end
            OP_SW: begin
                idex_n.mem_wr = 1'b1;
                idex_n.alu_imm = 1'b1; idex_n.imm = sext16(ifid.inst[15:0]);
            end
            OP_BEQ:  id_beq = 1'b1;
            OP_J:    id_j   = 1'b1;
            default: ;
        endcase

        case (br_fwd_a)
            FWD_EXMEM: br_a = exmem.alu;
            FWD_MEMWB: br_a = wb_data;
            default:   br_a = id_rs_val;
        endcase
        case (br_fwd_b)
            FWD_EXMEM: br_b = exmem.alu;
            FWD_MEMWB: br_b = wb_data;
            default:   br_b = id_rt_val;
        endcase

        id_pcp4   = ifid.pc + 32'd4;
        br_target = id_pcp4 + (sext16(ifid.inst[15:0]) << 2);
        j_target  = {id_pcp4[31:28], ifid.inst[25:0], 2'b00};
        br_taken  = (br_a == br_b);

        redirect_req = 1'b0;
        redirect_pc  = id_pcp4;
        if (id_beq && (br_taken != ifid.pred_taken)) begin
            redirect_req = 1'b1;
            redirect_pc  = br_taken ? br_target : id_pcp4;
        end
        // A jump whose target is already being fetched needs no flush.
        if (id_j && (pc != j_target)) begin
            redirect_req = 1'b1;
            redirect_pc  = j_target;
        end
    end

    mips_hazard_unit u_hazard (
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_beq       (id_beq),
        .redirect_req (redirect_req),
        .ex_rs        (idex.rs),
        .ex_rt        (idex.rt),
        .ex_rd        (idex.rd),
        .ex_we        (idex.reg_we),
        .ex_mrd       (idex.mem_rd),
        .mem_rd       (exmem.rd),
        .mem_we       (exmem.reg_we),
        .mem_mrd      (exmem.mem_rd),
        .wb_rd        (wb_rd),
        .wb_we        (wb_we),
        .stall        (stall),
        .flush        (flush),
        .fwd_a        (fwd_a),
        .fwd_b        (fwd_b),
        .br_fwd_a     (br_fwd_a),
        .br_fwd_b     (br_fwd_b)
    );

    // EX: forwarded operands and ALU.
    always_comb begin
        case (fwd_a)
            FWD_EXMEM: ex_a = exmem.alu;
            FWD_MEMWB: ex_a = wb_data;
            default:   ex_a = idex.rs_val;
        endcase
        case (fwd_b)
            FWD_EXMEM: ex_b_reg = exmem.alu;
            FWD_MEMWB: ex_b_reg = wb_data;
            default:   ex_b_reg = idex.rt_val;
        endcase
        ex_b = idex.alu_imm ? idex.imm : ex_b_reg;
        case (idex.alu_op)
            ALU_SUB: ex_alu = ex_a - ex_b;
            ALU_AND: ex_alu = ex_a & ex_b;
            ALU_OR:  ex_alu = ex_a | ex_b;
            ALU_SLT: ex_alu = ($signed(ex_a) < $signed(ex_b)) ? 32'd1 : 32'd0;
            ALU_LUI: ex_alu = {ex_b[15:0], 16'h0};
            default: ex_alu = ex_a + ex_b;
        endcase
        exmem_n         = '0;
        exmem_n.reg_we  = idex.reg_we;
        exmem_n.rd      = idex.rd;
        exmem_n.mem_rd  = idex.mem_rd;
        exmem_n.mem_wr  = idex.mem_wr;
        exmem_n.alu     = ex_alu;
        exmem_n.st_data = ex_b_reg;
    end

    // MEM: combinational load, result selection for WB.
    always_comb begin
        mem_ld         = dm[exmem.alu[11:2]];
        memwb_n        = '0;
        memwb_n.reg_we = exmem.reg_we;
        memwb_n.rd     = exmem.rd;
        memwb_n.wdata  = exmem.mem_rd ? mem_ld : exmem.alu;
    end

    // PC and pipeline registers; reset squashes everything in flight.
    always_ff @(posedge clk or negedge pc_rst_n) begin
        if (!pc_rst_n) begin
            pc    <= RESET_PC;
            ifid  <= '0;
            idex  <= '0;
            exmem <= '0;
            memwb <= '0;
        end else begin
            if (flush) begin
                pc   <= redirect_pc;
                ifid <= '0;
            end else if (!stall) begin
                pc   <= if_next;
                ifid <= '{pc: pc, inst: if_inst, pred_taken: if_pred};
            end
            idex  <= stall ? idex_t'('0) : idex_n;
            exmem <= exmem_n;
            memwb <= memwb_n;
        end
    end

    // Branch history: counters reset to strongly taken, trained on resolution.
    always_ff @(posedge clk or negedge pc_rst_n) begin
        if (!pc_rst_n) begin
            for (int i = 0; i < 8; i++) bht[i] <= 2'b11;
        end
`ifdef BHT_PREDICT_EN
        else if (id_beq && !stall) begin
            if (br_taken)
                bht[ifid.pc[4:2]] <= (bht[ifid.pc[4:2]] == 2'b11) ? 2'b11 : bht[ifid.pc[4:2]] + 2'b01;
            else
                bht[ifid.pc[4:2]] <= (bht[ifid.pc[4:2]] == 2'b00) ? 2'b00 : bht[ifid.pc[4:2]] - 2'b01;
        end
`endif
    end

    // WB register write; $0 is never written.
    always_ff @(posedge clk) begin
        if (wb_we && wb_rd != '0) reg_file[wb_rd] <= wb_data;
    end

    // Store in MEM.
    always_ff @(posedge clk) begin
        if (exmem.mem_wr) dm[exmem.alu[11:2]] <= exmem.st_data;
    end

endmodule

// File: tb/tb_mips5_pipe_core.sv
// Scoreboard bench: expected register commits are queued by the stimulus
// process and checked in order (value and cycle gap) by a WB monitor.
module tb_mips5_pipe_core;
    import mips_pkg::*;

    logic clk = 1'b0;
    logic pc_rst_n = 1'b0;
    always #5 clk = ~clk;

    mips5_pipe_core #(
        .INST_MEM_LENGTH (1024),
        .DATA_MEM_LENGTH (1024),
        .RESET_PC        (32'h0000_0000)
    ) dut (
        .clk      (clk),
        .pc_rst_n (pc_rst_n)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] val;
        int          gap;
    } exp_t;

    exp_t sb[$];
    exp_t golden[$];
    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int last_cyc = 0;
    int n_commit = 0;

`ifdef BHT_PREDICT_EN
    localparam int GAP_BR_TAKEN = 4;
    localparam int GAP_BR_NT    = 4;
    localparam logic [1:0] BHT0 = 2'b10;
`else
    localparam int GAP_BR_TAKEN = 5;
    localparam int GAP_BR_NT    = 3;
    localparam logic [1:0] BHT0 = 2'b11;
`endif

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] rtype(input logic [5:0] fn, input logic [4:0] rd,
                                          input logic [4:0] rs, input logic [4:0] rt);
        return {OP_RTYPE, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rt,
                                          input logic [4:0] rs, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic exp_t ex(input logic [4:0] rd, input logic [31:0] val, input int gap);
        exp_t e;
        e.rd = rd; e.val = val; e.gap = gap;
        return e;
    endfunction

    // WB monitor: every write to a nonzero register must be the next expected commit.
    always @(negedge clk) begin
        exp_t e;
        if (pc_rst_n && dut.wb_we && dut.wb_rd != 5'd0) begin
            n_commit++;
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_commit: got $%0d=%h, expected no commit", dut.wb_rd, dut.wb_data);
            end else begin
                e = sb.pop_front();
                chk($sformatf("commit%0d_rd", n_commit), 32'(dut.wb_rd), 32'(e.rd));
                chk($sformatf("commit%0d_val", n_commit), dut.wb_data, e.val);
                if (e.gap > 0) chk($sformatf("commit%0d_gap", n_commit), 32'(cyc - last_cyc), 32'(e.gap));
            end
            last_cyc <= cyc;
        end
    end

    task automatic wait_drain(input string nm);
        for (int k = 0; k < 400 && sb.size() != 0; k++) @(negedge clk);
        chk({nm, "_drain_remaining"}, 32'(sb.size()), 32'd0);
        repeat (12) @(negedge clk);
    endtask

    task automatic final_state(input string nm);
        logic [31:0] r [0:14];
        r[0] = 32'h0;  r[1] = 32'h11; r[2] = 32'h11; r[3] = 32'h8;  r[4] = 32'h3;
        r[5] = 32'h11; r[6] = 32'h22; r[7] = 32'h1234_5678; r[8] = 32'h0; r[9] = 32'h11;
        r[10] = 32'h1; r[11] = 32'hFFFF_FFEF; r[12] = 32'h1; r[13] = 32'h8; r[14] = 32'h0;
        for (int i = 0; i <= 14; i++)
            if (i != 8) chk($sformatf("%s_reg%0d", nm, i), dut.reg_file[i], r[i]);
        chk({nm, "_dm0"}, dut.dm[0], 32'h11);
        chk({nm, "_dm1"}, dut.dm[1], 32'h1234_5678);
        chk({nm, "_bht0"}, 32'(dut.bht[0]), 32'(BHT0));
        chk({nm, "_bht2"}, 32'(dut.bht[2]), 32'd3);
    endtask

    initial begin
        logic [31:0] prog [0:23];
        prog[0]  = itype(OP_ORI, 5'd9, 5'd0, 16'h0011);
        prog[1]  = itype(OP_SW,  5'd9, 5'd0, 16'h0000);
        prog[2]  = itype(OP_ORI, 5'd1, 5'd0, 16'h0005);
        prog[3]  = itype(OP_ORI, 5'd2, 5'd0, 16'h0003);
        prog[4]  = rtype(FN_ADDU, 5'd3, 5'd1, 5'd2);
        prog[5]  = rtype(FN_SUBU, 5'd4, 5'd3, 5'd1);
        prog[6]  = itype(OP_LW,  5'd5, 5'd0, 16'h0000);
        prog[7]  = rtype(FN_ADDU, 5'd6, 5'd5, 5'd5);
        prog[8]  = itype(OP_ORI, 5'd2, 5'd0, 16'h0011);
        prog[9]  = itype(OP_LW,  5'd1, 5'd0, 16'h0000);
        prog[10] = itype(OP_BEQ, 5'd2, 5'd1, 16'h0002);
        prog[11] = itype(OP_ORI, 5'd8, 5'd0, 16'h0BAD);
        prog[12] = itype(OP_ORI, 5'd8, 5'd0, 16'h0BAD);
        prog[13] = itype(OP_LUI, 5'd7, 5'd0, 16'h1234);
        prog[14] = itype(OP_ORI, 5'd7, 5'd7, 16'h5678);
        prog[15] = itype(OP_SW,  5'd7, 5'd0, 16'h0004);
        prog[16] = itype(OP_BEQ, 5'd1, 5'd0, 16'h0001);
        prog[17] = rtype(FN_SLT, 5'd10, 5'd4, 5'd3);
        prog[18] = rtype(FN_SUBU, 5'd11, 5'd0, 5'd1);
        prog[19] = rtype(FN_SLT, 5'd12, 5'd11, 5'd0);
        prog[20] = rtype(FN_AND, 5'd13, 5'd7, 5'd3);
        prog[21] = itype(OP_ORI, 5'd0, 5'd0, 16'hFFFF);
        prog[22] = rtype(FN_ADDU, 5'd14, 5'd0, 5'd0);
        prog[23] = {OP_J, 26'h17};
        for (int k = 0; k < 24; k++) dut.im[k] = prog[k];

        golden.push_back(ex(5'd9,  32'h11, 0));
        golden.push_back(ex(5'd1,  32'h5,  2));
        golden.push_back(ex(5'd2,  32'h3,  1));
        golden.push_back(ex(5'd3,  32'h8,  1));
        golden.push_back(ex(5'd4,  32'h3,  1));
        golden.push_back(ex(5'd5,  32'h11, 1));
        golden.push_back(ex(5'd6,  32'h22, 2));
        golden.push_back(ex(5'd2,  32'h11, 1));
        golden.push_back(ex(5'd1,  32'h11, 1));
        golden.push_back(ex(5'd7,  32'h1234_0000, GAP_BR_TAKEN));
        golden.push_back(ex(5'd7,  32'h1234_5678, 1));
        golden.push_back(ex(5'd10, 32'h1, GAP_BR_NT));
        golden.push_back(ex(5'd11, 32'hFFFF_FFEF, 1));
        golden.push_back(ex(5'd12, 32'h1, 1));
        golden.push_back(ex(5'd13, 32'h8, 1));
        golden.push_back(ex(5'd14, 32'h0, 2));

        // Clean run from reset.
        repeat (2) @(negedge clk);
        chk("reset_pc", dut.pc, 32'h0);
        chk("reset_wb_we", 32'(dut.wb_we), 32'd0);
        sb = golden;
        #1 pc_rst_n = 1'b1;
        wait_drain("run1");
        final_state("run1");

        // Restart, then pull reset mid-program and expect a full clean re-run.
        @(negedge clk); #1 pc_rst_n = 1'b0;
        sb = golden;
        @(negedge clk); #1 pc_rst_n = 1'b1;
        for (int k = 0; k < 200 && sb.size() > 9; k++) @(negedge clk);
        chk("midrun_progress", 32'(sb.size() <= 9), 32'd1);
        #1 pc_rst_n = 1'b0;
        sb = golden;
        #1;
        chk("midreset_pc", dut.pc, 32'h0);
        chk("midreset_wb_we", 32'(dut.wb_we), 32'd0);
        @(negedge clk); #1 pc_rst_n = 1'b1;
        wait_drain("run2");
        final_state("run2");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
